byte_word_packer: RTL and testbench
===================================

// Module: byte_word_packer
// PURPOSE
//  Consumes the registered 8-bit byte stream produced by the upstream 8-bit
//  D-flop stage (q[7:0], sampled on posedge clk). Packs consecutive bytes
//  into BYTES_PER_WORD-byte words, little-endian, and buffers the words in a
//  FIFO_DEPTH-entry FIFO. Words are presented downstream on a valid/ready
//  interface together with byte-keep and last flags.
// PARAMETERS
//  BYTES_PER_WORD  4  bytes per output word; legal values 2..8
//  FIFO_DEPTH      4  output FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1                   single clock; all state updates on posedge
//  reset      in   1                   synchronous, active-high reset
//  d          in   8                   input byte (upstream q)
//  in_valid   in   1                   d is valid this cycle
//  in_last    in   1                   d is the final byte of a packet
//  in_ready   out  1                   byte accepted when in_valid & in_ready at posedge
//  out_data   out  8*BYTES_PER_WORD    packed word at FIFO head; lane i = bits 8i+7:8i
//  out_keep   out  BYTES_PER_WORD      1 = lane holds a real byte
//  out_last   out  1                   word closes a packet
//  out_valid  out  1                   FIFO non-empty
//  out_ready  in   1                   word popped when out_valid & out_ready at posedge
// BEHAVIOUR
//  - Reset (sync, active-high). Clears lane index to 0, accumulator and keep to
//    0, and FIFO rd/wr pointers and count to 0. While reset is high,
//    in_ready=0 and out_valid=0. Outputs out_data, out_keep and out_last are 0
//    whenever out_valid=0. Reset mid-word discards the partial word; no
//    partial word is emitted.
//  - Accumulator state is lane index L, range 0..BYTES_PER_WORD-1. An
//    accepted byte is written to lane L and sets keep[L].
//    - If L==BYTES_PER_WORD-1 or in_last=1: the word {acc,keep,in_last} is
//      pushed to the FIFO in the same edge, and L, acc and keep return to 0.
//    - Otherwise L increments.
//  - Unfilled lanes of a short (in_last) word are 0 and have keep=0. A
//    single-byte packet gives keep=0x1.
//  - Ready rule: in_ready = !reset && (count != FIFO_DEPTH). This is
//    conservative: it gates every byte, not just word-completing ones.
//    in_ready does not depend combinationally on out_ready.
//  - Latency: a byte that completes a word at edge N, into an empty FIFO, gives
//    out_valid=1 in the cycle after N with that word at the head. There is no
//    combinational path from d to out_data.
//  - FIFO count update:
//    - push only: +1
//    - pop only: -1
//    - push and pop at the same edge: unchanged. Data order is preserved, and
//      the popped word is the old head.
//  - The pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits
//    wide, so full and empty are unambiguous.
//  - in_valid=0 leaves L and acc unchanged. The partial word persists
//    indefinitely; there is no timeout.
//  - out_ready=0 with out_valid=1: the head word and its flags are held
//    stable.
//  - d and in_last are ignored when in_valid=0 or in_ready=0.
// TESTING
//  1 Reset held for 2 cycles -> in_ready=0 and out_valid=0 during reset;
//    in_ready=1 and out_data=0 on the first cycle after reset.
//  2 Bytes 11,22,33,44 back-to-back with out_ready=1 -> one cycle after the
//    4th byte: out_data=0x44332211, out_keep=0xF, out_last=0, for 1 cycle.
//  3 Bytes AA then BB with in_last=1 -> out_data=0x0000BBAA, out_keep=0x3,
//    out_last=1.
//  4 out_ready=0 and 16 bytes 00..0F -> in_ready=0 after the 4th word; the
//    17th byte is stalled. Then out_ready=1 -> words pop in order:
//    03020100, 07060504, 0B0A0908, 0F0E0D0C; in_ready returns to 1 the cycle
//    after the first pop.
//  5 Bytes 01,02, then reset for 1 cycle, then 01,02,03,04 -> exactly one word
//    out, 0x04030201. The pre-reset bytes never appear.
//  6 400 cycles of random in_valid, in_last, d and out_ready, with reset
//    asserted 1/16 of cycles -> out_* matches a reference model every cycle.
//    Covers simultaneous push and pop at the full and empty boundaries.

Source files
------------

// File: rtl/byte_word_packer.sv
// Packs an 8-bit byte stream into little-endian words with keep/last flags
// and buffers the finished words in a small FIFO behind a valid/ready port.
module byte_word_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  d,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [8*BYTES_PER_WORD-1:0] out_data,
   output logic [BYTES_PER_WORD-1:0]   out_keep,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int LW = $clog2(BYTES_PER_WORD);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = 8 * BYTES_PER_WORD;
   localparam logic [LW-1:0] LANE_MAX   = LW'(BYTES_PER_WORD - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   logic [LW-1:0]             lane;
   logic [WW-1:0]             acc;
   logic [BYTES_PER_WORD-1:0] keep;

   logic [WW-1:0]             fifo_data [FIFO_DEPTH];
   logic [BYTES_PER_WORD-1:0] fifo_keep [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]     fifo_last;
   logic [PW-1:0]             rd_ptr;
   logic [PW-1:0]             wr_ptr;
   logic [CW-1:0]             count;

   logic                      accept;
   logic                      word_done;
   logic                      pop;
   logic [WW-1:0]             next_acc;
   logic [BYTES_PER_WORD-1:0] next_keep;

   // Ready gates every byte while full, so a word never has to wait for a slot.
   assign in_ready  = !reset && (count != COUNT_FULL);
   assign out_valid = !reset && (count != '0);
   assign accept    = in_valid && in_ready;
   assign word_done = accept && ((lane == LANE_MAX) || in_last);
   assign pop       = out_valid && out_ready;

   always_comb begin
      next_acc            = acc;
      next_keep           = keep;
      next_acc[8*lane +: 8] = d;
      next_keep[lane]     = 1'b1;
   end

   assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_keep = out_valid ? fifo_keep[rd_ptr] : '0;
   assign out_last = out_valid ? fifo_last[rd_ptr] : 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         lane   <= '0;
         acc    <= '0;
         keep   <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            if (word_done) begin
               lane <= '0;
               acc  <= '0;
               keep <= '0;
            end else begin
               lane <= lane + 1'b1;
               acc  <= next_acc;
               keep <= next_keep;
            end
         end
         if (word_done)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({word_done, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible once counted valid.
   always_ff @(posedge clk) begin
      if (word_done) begin
         fifo_data[wr_ptr] <= next_acc;
         fifo_keep[wr_ptr] <= next_keep;
         fifo_last[wr_ptr] <= in_last;
      end
   end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and randomized checks of byte_word_packer (4 bytes/word, 4-deep FIFO).
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  d = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state for the random phase
   int          m_lane;
   logic [31:0] m_acc;
   logic [3:0]  m_keep;
   logic [31:0] q_data [$];
   logic [3:0]  q_keep [$];
   logic        q_last [$];
   logic        exp_ready, exp_valid;

   byte_word_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      d = b; in_valid = 1'b1; in_last = last;
      step();
      in_valid = 1'b0; in_last = 1'b0; d = 8'h5A;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] data,
                           input logic [3:0] keep, input logic last);
      chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
      chk({tag, "_data"},  64'(out_data),  64'(data));
      chk({tag, "_keep"},  64'(out_keep),  64'(keep));
      chk({tag, "_last"},  64'(out_last),  64'(last));
   endtask

   initial begin
      // 1: reset behaviour
      @(negedge clk);
      chk("rst_ready0", 64'(in_ready), 0);
      chk("rst_valid0", 64'(out_valid), 0);
      step();
      chk("rst_ready1", 64'(in_ready), 0);
      chk("rst_valid1", 64'(out_valid), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 64'(in_ready), 1);
      chk("post_rst_data",  64'(out_data), 0);
      chk("post_rst_valid", 64'(out_valid), 0);

      // 2: full word, popped immediately
      out_ready = 1'b1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      chk_word("full_word", 32'h44332211, 4'hF, 1'b0);
      step();
      chk("full_word_gone", 64'(out_valid), 0);

      // 3: short packet
      send(8'hAA, 0); send(8'hBB, 1);
      chk_word("short_word", 32'h0000BBAA, 4'h3, 1'b1);
      step();
      chk("short_word_gone", 64'(out_valid), 0);

      // single-byte packet
      send(8'hD5, 1);
      chk_word("single_byte", 32'h000000D5, 4'h1, 1'b1);
      step();

      // 4: fill FIFO with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(i), 0);
      chk("full_ready", 64'(in_ready), 0);
      chk_word("full_head", 32'h03020100, 4'hF, 1'b0);
      d = 8'h10; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("stall_ready", 64'(in_ready), 0);
      chk_word("stall_hold", 32'h03020100, 4'hF, 1'b0);
      out_ready = 1'b1;
      step();
      chk("ready_after_pop", 64'(in_ready), 1);
      chk_word("pop2", 32'h07060504, 4'hF, 1'b0);
      step();
      chk_word("pop3", 32'h0B0A0908, 4'hF, 1'b0);
      step();
      chk_word("pop4", 32'h0F0E0D0C, 4'hF, 1'b0);
      step();
      chk("drained", 64'(out_valid), 0);

      // stalled byte must not have entered the accumulator
      send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
      chk_word("after_stall", 32'hA3A2A1A0, 4'hF, 1'b0);
      step();

      // partial word persists across idle cycles; d/in_last ignored when invalid
      send(8'hC0, 0);
      d = 8'hFF; in_last = 1'b1;
      step(); step(); step();
      in_last = 1'b0;
      chk("idle_no_word", 64'(out_valid), 0);
      send(8'hC1, 1);
      chk_word("held_partial", 32'h0000C1C0, 4'h3, 1'b1);
      step();

      // 5: reset mid-word discards partial
      send(8'h01, 0); send(8'h02, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(in_ready), 0);
      step();
      reset = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      chk_word("after_rst", 32'h04030201, 4'hF, 1'b0);
      step();
      chk("after_rst_one_word", 64'(out_valid), 0);

      // 6: random traffic against the reference model
      m_lane = 0; m_acc = '0; m_keep = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset     = (cyc == 0) || ($urandom_range(15) == 0);
         in_valid  = ($urandom_range(3) != 0);
         in_last   = ($urandom_range(4) == 0);
         d         = 8'($urandom_range(255));
         out_ready = (cyc < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
         #1;
         exp_ready = !reset && (q_data.size() != 4);
         exp_valid = !reset && (q_data.size() != 0);
         chk("rnd_ready", 64'(in_ready),  64'(exp_ready));
         chk("rnd_valid", 64'(out_valid), 64'(exp_valid));
         chk("rnd_data",  64'(out_data),  exp_valid ? 64'(q_data[0]) : 64'(0));
         chk("rnd_keep",  64'(out_keep),  exp_valid ? 64'(q_keep[0]) : 64'(0));
         chk("rnd_last",  64'(out_last),  exp_valid ? 64'(q_last[0]) : 64'(0));
         if (reset) begin
            m_lane = 0; m_acc = '0; m_keep = '0;
            q_data.delete(); q_keep.delete(); q_last.delete();
         end else begin
            if (exp_valid && out_ready) begin
               void'(q_data.pop_front());
               void'(q_keep.pop_front());
               void'(q_last.pop_front());
            end
            if (in_valid && exp_ready) begin
               m_acc[8*m_lane +: 8] = d;
               m_keep[m_lane]       = 1'b1;
               if (m_lane == 3 || in_last) begin
                  q_data.push_back(m_acc);
                  q_keep.push_back(m_keep);
                  q_last.push_back(in_last);
                  m_lane = 0; m_acc = '0; m_keep = '0;
               end else begin
                  m_lane++;
               end
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
